// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state type and segment decode for the infinity-mode display
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic ACTIVE_LEVEL = 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, CONV_S, CONV_T, COMMIT} state_e;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - serial double-dabble converter, MSB-first, one bit per cycle
module bin2bcd_seq #(
  parameter int W  = 7,
  parameter int ND = 3,
  parameter int CW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    din,
  input  logic [CW-1:0]   nbits,
  output logic            done,
  output logic [4*ND-1:0] bcd
);

  logic [W-1:0]    bin_q, bin_d, src_bin;
  logic [4*ND-1:0] bcd_q, bcd_d, src_bcd, adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            act_q, act_d;

  // start performs the first shift directly on din; shorter words are left-justified by the caller
  always_comb begin
    src_bin = start ? din : bin_q;
    src_bcd = start ? '0 : bcd_q;
    adj     = '0;
    for (int i = 0; i < ND; i++) begin
      adj[4*i +: 4] = (src_bcd[4*i +: 4] >= 4'd5) ? src_bcd[4*i +: 4] + 4'd3 : src_bcd[4*i +: 4];
    end
    done  = act_q && (cnt_q == '0);
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    act_d = act_q;
    if (start || (act_q && (cnt_q != '0))) begin
      {bcd_d, bin_d} = {adj, src_bin} << 1;
      cnt_d = start ? nbits - 1'b1 : cnt_q - 1'b1;
    end
    if (start) begin
      act_d = 1'b1;
    end else if (done) begin
      act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/seg_scan_infinity.sv
// rtl/seg_scan_infinity.sv - infinity-mode score/timer display: BCD conversion, digit scan, game-over blink
module seg_scan_infinity #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] score,
  input  logic [5:0] timer,
  input  logic       gameover,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       busy
);
  import seg_pkg::*;

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = $clog2(SCAN_DIV);
  localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  if (SCAN_DIV < 32) begin : g_bad_scan_div
    $error("seg_scan_infinity: CLK_HZ/SCAN_HZ must be at least 32");
  end

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic               blink_q, blink_d;
  state_e             state_q, state_d;
  logic [11:0]        sc_bcd_q, sc_bcd_d;
  logic [5:0]         tim_hold_q, tim_hold_d;
  logic [15:0]        digs_q, digs_d;
  logic               hund_q, hund_d;
  logic               mode_q, mode_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic        scan_tick, frame_trig, blank;
  logic        cv_start, cv_done;
  logic [6:0]  cv_din;
  logic [2:0]  cv_nbits;
  logic [11:0] cv_bcd;

  assign scan_tick  = (scan_cnt_q == SCAN_LAST);
  assign frame_trig = scan_tick && (idx_q == 2'd1);

  bin2bcd_seq #(.W(7), .ND(3)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cv_start),
    .din   (cv_din),
    .nbits (cv_nbits),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  // one converter shared: score first, then timer, then all digits committed together
  always_comb begin
    state_d    = state_q;
    cv_start   = 1'b0;
    cv_din     = '0;
    cv_nbits   = '0;
    sc_bcd_d   = sc_bcd_q;
    tim_hold_d = tim_hold_q;
    digs_d     = digs_q;
    hund_d     = hund_q;
    case (state_q)
      IDLE: if (frame_trig) begin
        cv_start   = 1'b1;
        cv_din     = score;
        cv_nbits   = 3'd7;
        tim_hold_d = timer;
        state_d    = CONV_S;
      end
      CONV_S: if (cv_done) begin
        sc_bcd_d = cv_bcd;
        cv_start = 1'b1;
        cv_din   = {tim_hold_q, 1'b0};
        cv_nbits = 3'd6;
        state_d  = CONV_T;
      end
      CONV_T: if (cv_done) state_d = COMMIT;
      COMMIT: begin
        digs_d  = {cv_bcd[7:0], sc_bcd_q[7:0]};
        hund_d  = |sc_bcd_q[11:8];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE) || frame_trig;

  always_comb begin
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + 1'b1;
    idx_d      = scan_tick ? idx_q - 2'd1 : idx_q;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (gameover) begin
      blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
      blink_d     = (blink_cnt_q == BLINK_LAST) ? ~blink_q : blink_q;
    end
  end

  // outputs move only on a scan tick or when the blank/scan selection flips
  always_comb begin
    blank  = (gameover && blink_q) || (!enable && !gameover);
    mode_d = blank;
    an_d   = an_q;
    seg_d  = seg_q;
    if (scan_tick || (blank != mode_q)) begin
      if (blank) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = seg_decode(digs_q[{idx_d, 2'b00} +: 4]);
        if ((idx_d == 2'd0) && hund_q) seg_d[7] = ACTIVE_LEVEL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      state_q     <= IDLE;
      sc_bcd_q    <= '0;
      tim_hold_q  <= '0;
      digs_q      <= '0;
      hund_q      <= 1'b0;
      mode_q      <= 1'b1;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      state_q     <= state_d;
      sc_bcd_q    <= sc_bcd_d;
      tim_hold_q  <= tim_hold_d;
      digs_q      <= digs_d;
      hund_q      <= hund_d;
      mode_q      <= mode_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_infinity.sv
// tb/tb_seg_scan_infinity.sv - randomized bench for seg_scan_infinity against a cycle-count display model
module tb_seg_scan_infinity;

  localparam int CLK_HZ   = 3200;
  localparam int SCAN_HZ  = 100;
  localparam int BLINK_HZ = 5;
  localparam int TICK     = CLK_HZ / SCAN_HZ;
  localparam int FRAME    = 4 * TICK;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
  localparam int LAT      = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       gameover = 1'b0;
  logic [6:0] score = '0;
  logic [5:0] timer = '0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       busy;

  int total = 0;
  int bad = 0;

  int         n, com_sc, com_tm, pend_at, pend_sc, pend_tm, go_cnt;
  bit         pend_v, phase, prev_blank;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;

  seg_scan_infinity #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .score    (score),
    .timer    (timer),
    .gameover (gameover),
    .an       (an),
    .seg      (seg),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(int d);
    logic [7:0] lit;
    case (d)
      0: lit = 8'h3F;  1: lit = 8'h06;  2: lit = 8'h5B;  3: lit = 8'h4F;  4: lit = 8'h66;
      5: lit = 8'h6D;  6: lit = 8'h7D;  7: lit = 8'h07;  8: lit = 8'h7F;  9: lit = 8'h6F;
      default: lit = 8'h00;
    endcase
    return ~lit;
  endfunction

  function automatic logic [7:0] digit_seg(int idx);
    case (idx)
      3:       return seg_of(com_tm / 10);
      2:       return seg_of(com_tm % 10);
      1:       return seg_of((com_sc % 100) / 10);
      default: return seg_of(com_sc % 10) & ((com_sc >= 100) ? 8'h7F : 8'hFF);
    endcase
  endfunction

  function automatic void model_reset();
    n = 0; com_sc = 0; com_tm = 0; pend_v = 0; pend_at = 0; pend_sc = 0; pend_tm = 0;
    go_cnt = 0; phase = 0; prev_blank = 1; exp_an = 4'hF; exp_seg = 8'hFF;
  endfunction

  task automatic step();
    bit         blank_c;
    int         idx;
    logic [3:0] one;
    one = 4'b0001;
    blank_c = (gameover && phase) || (!enable && !gameover);
    @(posedge clk);
    n++;
    idx = (4 - (n / TICK) % 4) % 4;
    if ((n % TICK == 0) || (blank_c != prev_blank)) begin
      if (blank_c) begin
        exp_an = 4'hF; exp_seg = 8'hFF;
      end else begin
        exp_an = ~(one << idx); exp_seg = digit_seg(idx);
      end
    end
    prev_blank = blank_c;
    if (pend_v && n == pend_at) begin
      com_sc = pend_sc; com_tm = pend_tm; pend_v = 0;
    end
    if (n % FRAME == 0) begin
      pend_v = 1; pend_at = n + LAT; pend_sc = int'(score); pend_tm = int'(timer);
    end
    if (gameover) begin
      go_cnt++; phase = ((go_cnt / HALF) % 2) == 1;
    end else begin
      go_cnt = 0; phase = 0;
    end
    @(negedge clk);
    check_eq($sformatf("an@%0d", n), an, exp_an);
    check_eq($sformatf("seg@%0d", n), seg, exp_seg);
    check_eq($sformatf("busy@%0d", n), busy, ((n + 1) >= FRAME && (n + 1) % FRAME <= LAT) ? 1 : 0);
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_to(int r);
    for (int i = 0; i < FRAME && (n % FRAME) != r; i++) step();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_an", an, 4'hF);
    check_eq("rst_seg", seg, 8'hFF);
    check_eq("rst_busy", busy, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_hold_an", an, 4'hF);
    check_eq("rst_hold_busy", busy, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    enable = 1'b1; score = 7'd47; timer = 6'd16;
    run(3 * FRAME);
    score = 7'd127; timer = 6'd63;
    run(2 * FRAME);
    score = 7'd100;
    run(2 * FRAME);
    score = 7'd99;
    run(2 * FRAME);
    score = 7'd19; timer = 6'd8;
    run_to(1);
    score = 7'd20;
    run(3 * FRAME);
    for (int f = 0; f < 12; f++) begin
      score  = 7'($urandom_range(0, 127));
      timer  = 6'($urandom_range(0, 63));
      enable = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 31) == 0) score = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 63) == 0) timer = 6'($urandom_range(0, 63));
        step();
      end
    end
    enable = 1'b1; score = 7'd55; timer = 6'd0;
    run_to(FRAME - 1);
    gameover = 1'b1;
    run(4 * HALF + 40);
    enable = 1'b0;
    run(10);
    gameover = 1'b0;
    run(9 * TICK);
    enable = 1'b1; score = 7'd88; timer = 6'd42;
    run(2 * FRAME);
    run_to(5);
    do_reset();
    run(2 * FRAME + 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
